// File: rtl/alarm_pkg.sv
// Shared types and widths for the temperature alarm controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    BOSTA,
    ISTEK,
    YAZ,
    KONTROL,
    BEKLE
  } durum_t;

  localparam int SICAKLIK_W = 7;
  localparam int SAYI_W     = 8;

endpackage

// File: rtl/periyot_sayaci.sv
// Loadable down-counter producing a one-cycle tick every PERIYOT cycles
// while running; a load restarts the count from PERIYOT-1.
module periyot_sayaci #(
  parameter int PERIYOT = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic calis_i,
  input  logic yukle_i,
  output logic tick_o
);

  localparam int SW = (PERIYOT > 1) ? $clog2(PERIYOT) : 1;
  localparam logic [SW-1:0] YUKLE_DEGER = SW'(PERIYOT - 1);

  logic [SW-1:0] sayac_q, sayac_d;

  // Next count: load wins, otherwise count down and wrap to the reload value.
  always_comb begin
    sayac_d = sayac_q;
    if (yukle_i) begin
      sayac_d = YUKLE_DEGER;
    end else if (calis_i) begin
      sayac_d = (sayac_q == '0) ? YUKLE_DEGER : sayac_q - SW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sayac_q <= '0;
    end else begin
      sayac_q <= sayac_d;
    end
  end

  assign tick_o = calis_i && !yukle_i && (sayac_q == '0);

endmodule

// File: rtl/alarm_denetleyici.sv
// Sequencer for the temperature-averaging/alarm datapath: sensor request
// handshake with timeout, one-cycle write strobe to the datapath, warm-up
// qualification and a latched alarm cleared by software acknowledge.
// Optional macro ALARM_ARDISIK_EN: alarm requires two consecutive qualified
// evaluations with dp_alarm=1 instead of one.
module alarm_denetleyici
  import alarm_pkg::*;
#(
  parameter int PERIYOT     = 1000,
  parameter int ZAMAN_ASIMI = 16,
  parameter int ISINMA      = 4
) (
  input  logic                  saat,
  input  logic                  reset,
  input  logic                  etkin,
  output logic                  olcum_istek,
  input  logic                  olcum_gecerli,
  input  logic [SICAKLIK_W-1:0] olcum_veri,
  output logic [SICAKLIK_W-1:0] dp_sicaklik,
  output logic                  dp_yaz,
  output logic                  dp_temizle,
  input  logic                  dp_alarm,
  input  logic                  alarm_onay,
  output logic                  alarm,
  output logic                  hata,
  output logic [SAYI_W-1:0]     ornek_sayisi
);

  localparam int ZW = $clog2(ZAMAN_ASIMI + 1);
  localparam int IW = $clog2(ISINMA + 1);
  localparam logic [ZW-1:0] ZAMAN_SON  = ZW'(ZAMAN_ASIMI - 1);
  localparam logic [IW-1:0] ISINMA_TAM = IW'(ISINMA);

  durum_t                durum_q, durum_d;
  logic [ZW-1:0]         zaman_q, zaman_d;
  logic [IW-1:0]         isinma_q, isinma_d;
  logic [SICAKLIK_W-1:0] sicaklik_q, sicaklik_d;
  logic [SAYI_W-1:0]     sayi_q, sayi_d;
  logic                  temizle_q, temizle_d;
  logic                  alarm_q, alarm_d;
  logic                  hata_q, hata_d;
  logic                  son_durum_q, son_durum_d;
`ifdef ALARM_ARDISIK_EN
  logic                  ardisik_q, ardisik_d;
`endif

  logic yukle, tick, zaman_asti, alarm_kur, nitelikli;

  periyot_sayaci #(
    .PERIYOT(PERIYOT)
  ) u_periyot (
    .clk_i  (saat),
    .rst_ni (reset),
    .calis_i(etkin),
    .yukle_i(yukle),
    .tick_o (tick)
  );

  // Next-state and register updates; dropping etkin forces BOSTA from any state.
  always_comb begin
    durum_d     = durum_q;
    zaman_d     = '0;
    isinma_d    = isinma_q;
    sicaklik_d  = sicaklik_q;
    sayi_d      = sayi_q;
    temizle_d   = 1'b0;
    son_durum_d = son_durum_q;
    yukle       = 1'b0;
    zaman_asti  = 1'b0;
    alarm_kur   = 1'b0;
    nitelikli   = 1'b0;
`ifdef ALARM_ARDISIK_EN
    ardisik_d   = ardisik_q;
`endif
    if (!etkin) begin
      durum_d = BOSTA;
    end else begin
      case (durum_q)
        BOSTA: begin
          // First enabled cycle clears history; the next one starts requesting.
          if (!temizle_q) begin
            temizle_d = 1'b1;
            isinma_d  = '0;
          end else begin
            durum_d = ISTEK;
            yukle   = 1'b1;
          end
        end
        ISTEK: begin
          if (olcum_gecerli) begin
            sicaklik_d = olcum_veri;
            durum_d    = YAZ;
          end else if (zaman_q == ZAMAN_SON) begin
            zaman_asti = 1'b1;
            durum_d    = BEKLE;
          end else begin
            zaman_d = zaman_q + ZW'(1);
          end
        end
        YAZ: begin
          sayi_d = sayi_q + SAYI_W'(1);
          if (isinma_q != ISINMA_TAM) isinma_d = isinma_q + IW'(1);
          durum_d = KONTROL;
        end
        KONTROL: begin
          son_durum_d = dp_alarm;
          nitelikli   = (isinma_q == ISINMA_TAM);
`ifdef ALARM_ARDISIK_EN
          ardisik_d   = nitelikli && dp_alarm;
          alarm_kur   = nitelikli && dp_alarm && ardisik_q;
`else
          alarm_kur   = nitelikli && dp_alarm;
`endif
          durum_d     = BEKLE;
        end
        BEKLE: begin
          if (tick) durum_d = ISTEK;
        end
        default: durum_d = BOSTA;
      endcase
    end
`ifdef ALARM_ARDISIK_EN
    if (zaman_asti || durum_d == BOSTA) ardisik_d = 1'b0;
`endif
    // Set beats acknowledge for both sticky flags.
    hata_d  = zaman_asti ? 1'b1 : (alarm_onay ? 1'b0 : hata_q);
    alarm_d = alarm_kur ? 1'b1 : ((alarm_onay && !son_durum_q) ? 1'b0 : alarm_q);
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum_q     <= BOSTA;
      zaman_q     <= '0;
      isinma_q    <= '0;
      sicaklik_q  <= '0;
      sayi_q      <= '0;
      temizle_q   <= 1'b0;
      alarm_q     <= 1'b0;
      hata_q      <= 1'b0;
      son_durum_q <= 1'b0;
`ifdef ALARM_ARDISIK_EN
      ardisik_q   <= 1'b0;
`endif
    end else begin
      durum_q     <= durum_d;
      zaman_q     <= zaman_d;
      isinma_q    <= isinma_d;
      sicaklik_q  <= sicaklik_d;
      sayi_q      <= sayi_d;
      temizle_q   <= temizle_d;
      alarm_q     <= alarm_d;
      hata_q      <= hata_d;
      son_durum_q <= son_durum_d;
`ifdef ALARM_ARDISIK_EN
      ardisik_q   <= ardisik_d;
`endif
    end
  end

  assign olcum_istek  = (durum_q == ISTEK);
  assign dp_yaz       = (durum_q == YAZ) && etkin;
  assign dp_temizle   = temizle_q;
  assign dp_sicaklik  = sicaklik_q;
  assign alarm        = alarm_q;
  assign hata         = hata_q;
  assign ornek_sayisi = sayi_q;

endmodule
